// File: rtl/spi_slave_responder.sv
// spi_slave_responder
//   SPI target for the SD-card / frequency-generator link. sclk, cs_n and
//   mosi are oversampled on trigger_clk; all four CPOL/CPHA modes are
//   supported, mode is latched at the start of each select. Frames are DATA_W
//   bits, LSB first unless MSB_FIRST. Back-to-back frames run without
//   toggling cs_n.
//
//   Build option: define SPI_SLAVE_RXFIFO_EN for a FIFO_DEPTH-entry RX FIFO;
//   otherwise RX storage is a single holding register.
//
// Ports
//   trigger_clk, rst_n   system clock (>= 8x sclk), async active-low reset
//   cpol, cpha           SPI mode, captured when synced cs_n falls
//   sclk, cs_n, mosi     asynchronous SPI inputs from the master
//   miso, miso_oe        serial data to the master and its output enable
//   tx_data/valid/ready  TX byte stream into a one-entry holding register
//   rx_data/valid/ready  RX byte stream out of RX storage
//   busy                 frame in progress
//   overrun, underrun    sticky error flags, cleared by a clear_err pulse
module spi_slave_responder #(
   parameter int unsigned       DATA_W      = 8,
   parameter int unsigned       SYNC_STAGES = 2,
   parameter bit                MSB_FIRST   = 1'b0,
   parameter logic [DATA_W-1:0] IDLE_FILL   = 8'hFF,
   parameter int unsigned       FIFO_DEPTH  = 4
) (
   input  logic              trigger_clk,
   input  logic              rst_n,
   input  logic              cpol,
   input  logic              cpha,
   input  logic              sclk,
   input  logic              cs_n,
   input  logic              mosi,
   output logic              miso,
   output logic              miso_oe,
   input  logic [DATA_W-1:0] tx_data,
   input  logic              tx_valid,
   output logic              tx_ready,
   output logic [DATA_W-1:0] rx_data,
   output logic              rx_valid,
   input  logic              rx_ready,
   output logic              busy,
   output logic              overrun,
   output logic              underrun,
   input  logic              clear_err
);

   localparam int unsigned   CW        = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam logic [CW-1:0] LAST_BIT  = CW'(DATA_W - 1);
   localparam logic [CW-1:0] FIRST_IDX = MSB_FIRST ? LAST_BIT : '0;

   typedef enum logic [1:0] {IDLE, LOAD, SHIFT} state_t;
   state_t state, state_nxt;

   logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, mosi_sync;
   logic sclk_s, cs_s, mosi_s, sclk_d, cs_d;
   logic cpol_q, cpha_q;
   logic sclk_rise, sclk_fall, lead_edge, trail_edge, sample_edge, shift_edge;
   logic cs_fall, cs_rise;
   logic load_evt, do_sample, do_shift, byte_done;
   logic [CW-1:0] bit_cnt, bit_idx;
   logic [DATA_W-1:0] tx_hold, tx_sh, rx_sh, rx_word, word_q, load_byte;
   logic tx_full, tx_wr, done_q, rx_room, rx_pop;

   assign sclk_s = sclk_sync[SYNC_STAGES-1];
   assign cs_s   = cs_sync[SYNC_STAGES-1];
   assign mosi_s = mosi_sync[SYNC_STAGES-1];

   always_ff @(posedge trigger_clk or negedge rst_n) begin
      if (!rst_n) begin
         sclk_sync <= '0;
         cs_sync   <= '1;
         mosi_sync <= '0;
         sclk_d    <= 1'b0;
         cs_d      <= 1'b1;
      end else begin
         sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
         cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs_n};
         mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
         sclk_d    <= sclk_s;
         cs_d      <= cs_s;
      end
   end

   assign sclk_rise   = sclk_s & ~sclk_d;
   assign sclk_fall   = ~sclk_s & sclk_d;
   assign lead_edge   = cpol_q ? sclk_fall : sclk_rise;
   assign trail_edge  = cpol_q ? sclk_rise : sclk_fall;
   assign sample_edge = cpha_q ? trail_edge : lead_edge;
   assign shift_edge  = cpha_q ? lead_edge : trail_edge;
   assign cs_fall     = ~cs_s & cs_d;
   assign cs_rise     = cs_s & ~cs_d;

   // bit_cnt counts sample edges since the last load; indexing miso by it
   // makes the first shift edge after any load repeat the first bit, which
   // covers both the cpha=1 frame start and the cpha=0 back-to-back reload.
   assign bit_idx   = MSB_FIRST ? (LAST_BIT - bit_cnt) : bit_cnt;
   assign load_byte = tx_full ? tx_hold : IDLE_FILL;
   assign tx_wr     = tx_valid & ~tx_full;
   assign tx_ready  = ~tx_full;
   assign busy      = (state != IDLE);

   always_comb begin
      rx_word          = rx_sh;
      rx_word[bit_idx] = mosi_s;
   end

   always_ff @(posedge trigger_clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      load_evt  = 1'b0;
      do_sample = 1'b0;
      do_shift  = 1'b0;
      byte_done = 1'b0;
      if (cs_rise) begin
         state_nxt = IDLE;
      end else begin
         case (state)
            IDLE: begin
               if (cs_fall) begin
                  state_nxt = LOAD;
                  load_evt  = 1'b1;
               end
            end
            LOAD, SHIFT: begin
               state_nxt = SHIFT;
               do_sample = sample_edge;
               do_shift  = shift_edge;
               if (sample_edge && (bit_cnt == LAST_BIT)) begin
                  byte_done = 1'b1;
                  load_evt  = 1'b1;
               end
            end
            default: state_nxt = IDLE;
         endcase
      end
   end

   always_ff @(posedge trigger_clk or negedge rst_n) begin
      if (!rst_n) begin
         cpol_q   <= 1'b0;
         cpha_q   <= 1'b0;
         tx_hold  <= '0;
         tx_full  <= 1'b0;
         tx_sh    <= '0;
         miso     <= 1'b0;
         miso_oe  <= 1'b0;
         bit_cnt  <= '0;
         rx_sh    <= '0;
         done_q   <= 1'b0;
         word_q   <= '0;
         underrun <= 1'b0;
         overrun  <= 1'b0;
      end else begin
         if ((state == IDLE) && cs_fall) begin
            cpol_q <= cpol;
            cpha_q <= cpha;
         end
         if (tx_wr) tx_hold <= tx_data;
         // A load consumes the old content; a write in the same cycle refills.
         tx_full <= tx_wr | (tx_full & ~load_evt);
         if (load_evt) tx_sh <= load_byte;
         if (cs_rise) begin
            miso    <= 1'b0;
            miso_oe <= 1'b0;
         end else if (load_evt) begin
            miso    <= load_byte[FIRST_IDX];
            miso_oe <= 1'b1;
         end else if (do_shift) begin
            miso <= tx_sh[bit_idx];
         end
         if (cs_rise || load_evt) bit_cnt <= '0;
         else if (do_sample)      bit_cnt <= bit_cnt + 1'b1;
         if (do_sample) rx_sh <= rx_word;
         done_q <= byte_done;
         if (byte_done) word_q <= rx_word;
         underrun <= (load_evt & ~tx_full) | (underrun & ~clear_err);
         overrun  <= (done_q & ~rx_room) | (overrun & ~clear_err);
      end
   end

`ifdef SPI_SLAVE_RXFIFO_EN
   localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam logic [PW:0] FULL_CNT = (PW + 1)'(FIFO_DEPTH);

   logic [DATA_W-1:0] fifo_mem [FIFO_DEPTH];
   logic [PW-1:0]     wr_ptr, rd_ptr;
   logic [PW:0]       fill;
   logic              rx_push;

   assign rx_valid = (fill != '0);
   assign rx_data  = fifo_mem[rd_ptr];
   assign rx_pop   = rx_valid & rx_ready;
   assign rx_room  = (fill != FULL_CNT) | rx_pop;
   assign rx_push  = done_q & rx_room;

   always_ff @(posedge trigger_clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         fill   <= '0;
         for (int unsigned i = 0; i < FIFO_DEPTH; i++) fifo_mem[i] <= '0;
      end else begin
         if (rx_push) begin
            fifo_mem[wr_ptr] <= word_q;
            wr_ptr           <= wr_ptr + 1'b1;
         end
         if (rx_pop) rd_ptr <= rd_ptr + 1'b1;
         fill <= fill + {{PW{1'b0}}, rx_push} - {{PW{1'b0}}, rx_pop};
      end
   end
`else
   assign rx_pop  = rx_valid & rx_ready;
   assign rx_room = ~rx_valid | rx_ready;

   always_ff @(posedge trigger_clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_data  <= '0;
         rx_valid <= 1'b0;
      end else if (done_q && rx_room) begin
         rx_data  <= word_q;
         rx_valid <= 1'b1;
      end else if (rx_pop) begin
         rx_valid <= 1'b0;
      end
   end
`endif

endmodule

// File: tb/tb_spi_slave_responder.sv
// Directed bench for spi_slave_responder. A frame-level model (TX holding
// queue, RX storage queue with capacity, expected sticky flags) predicts the
// master-side miso bits and the idle-time outputs.
module tb_spi_slave_responder;

   localparam int HALF = 8;
`ifdef SPI_SLAVE_RXFIFO_EN
   localparam int RX_CAP = 4;
`else
   localparam int RX_CAP = 1;
`endif

   logic       trigger_clk = 1'b0;
   logic       rst_n, cpol, cpha, sclk, cs_n, mosi;
   logic       miso, miso_oe, tx_valid, tx_ready, rx_valid, rx_ready;
   logic       busy, overrun, underrun, clear_err;
   logic [7:0] tx_data, rx_data;

   always #5 trigger_clk = ~trigger_clk;

   spi_slave_responder #(.DATA_W(8), .SYNC_STAGES(2), .MSB_FIRST(1'b0),
                         .IDLE_FILL(8'hFF), .FIFO_DEPTH(4)) dut (
      .trigger_clk(trigger_clk), .rst_n(rst_n), .cpol(cpol), .cpha(cpha),
      .sclk(sclk), .cs_n(cs_n), .mosi(mosi), .miso(miso), .miso_oe(miso_oe),
      .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
      .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
      .busy(busy), .overrun(overrun), .underrun(underrun), .clear_err(clear_err)
   );

   int         checks = 0;
   int         errors = 0;
   bit         quiet  = 1'b0;
   logic [7:0] txq[$];
   logic [7:0] rxq[$];
   bit         exp_ovr = 1'b0;
   bit         exp_unr = 1'b0;
   logic [7:0] mo_bytes [4];
   logic [7:0] got [4];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Idle-time compare: whenever no frame or handshake is in flight, all
   // outputs must match the model.
   always @(negedge trigger_clk) begin
      if (quiet) begin
         chk("idle_busy", busy, 0);
         chk("idle_oe", miso_oe, 0);
         chk("idle_miso", miso, 0);
         chk("idle_tx_ready", tx_ready, (txq.size() == 0) ? 1 : 0);
         chk("idle_rx_valid", rx_valid, (rxq.size() != 0) ? 1 : 0);
         if (rxq.size() != 0) chk("idle_rx_data", rx_data, rxq[0]);
         chk("idle_overrun", overrun, exp_ovr);
         chk("idle_underrun", underrun, exp_unr);
      end
   end

   task automatic wait_cyc(input int n);
      repeat (n) @(posedge trigger_clk);
      #1;
   endtask

   task automatic push_tx(input logic [7:0] d);
      quiet = 1'b0;
      @(negedge trigger_clk);
      tx_data  = d;
      tx_valid = 1'b1;
      @(posedge trigger_clk);
      #1 tx_valid = 1'b0;
      txq.push_back(d);
      wait_cyc(2);
      quiet = 1'b1;
   endtask

   task automatic pop_rx(input logic [7:0] exp);
      quiet = 1'b0;
      @(negedge trigger_clk);
      chk("pop_valid", rx_valid, 1);
      chk("pop_data", rx_data, exp);
      rx_ready = 1'b1;
      @(posedge trigger_clk);
      #1 rx_ready = 1'b0;
      if (rxq.size() != 0) void'(rxq.pop_front());
      wait_cyc(2);
      quiet = 1'b1;
   endtask

   task automatic clear_errs();
      quiet = 1'b0;
      @(negedge trigger_clk);
      clear_err = 1'b1;
      @(posedge trigger_clk);
      #1 clear_err = 1'b0;
      exp_ovr = 1'b0;
      exp_unr = 1'b0;
      wait_cyc(2);
      quiet = 1'b1;
   endtask

   task automatic sample_bit(input int b, input logic [7:0] exp_byte);
      got[b/8][b%8] = miso;
      chk("miso_bit", miso, exp_byte[b%8]);
      chk("frame_oe", miso_oe, 1);
      chk("frame_busy", busy, 1);
   endtask

   // One cs_n-low window of nbits bits. Every byte boundary (and the select
   // itself) loads a TX slot; every complete byte lands in RX storage.
   task automatic run_frame(input bit pol, input bit pha, input int nbits);
      logic [7:0] slot [5];
      quiet = 1'b0;
      for (int s = 0; s <= nbits / 8; s++) begin
         if (txq.size() != 0) slot[s] = txq.pop_front();
         else begin
            slot[s] = 8'hFF;
            exp_unr = 1'b1;
         end
      end
      for (int k = 0; k < 4; k++) got[k] = '0;
      cpol = pol;
      cpha = pha;
      sclk = pol;
      mosi = 1'b0;
      wait_cyc(10);
      cs_n = 1'b0;
      for (int b = 0; b < nbits; b++) begin
         if (!pha) mosi = mo_bytes[b/8][b%8];
         wait_cyc(HALF);
         // mode pins wander mid-frame; the latched mode must hold
         if (b == 0) begin
            cpol = ~pol;
            cpha = ~pha;
         end
         sclk = ~pol;
         if (pha) mosi = mo_bytes[b/8][b%8];
         else     sample_bit(b, slot[b/8]);
         wait_cyc(HALF);
         sclk = pol;
         if (pha) sample_bit(b, slot[b/8]);
      end
      wait_cyc(HALF);
      cs_n = 1'b1;
      wait_cyc(2);
      cpol = pol;
      cpha = pha;
      for (int k = 0; k < nbits / 8; k++) begin
         if (rxq.size() < RX_CAP) rxq.push_back(mo_bytes[k]);
         else exp_ovr = 1'b1;
      end
      wait_cyc(12);
      quiet = 1'b1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      rst_n = 1'b0; cpol = 1'b0; cpha = 1'b0; sclk = 1'b0; cs_n = 1'b1;
      mosi = 1'b0; tx_data = '0; tx_valid = 1'b0; rx_ready = 1'b0; clear_err = 1'b0;
      wait_cyc(3);
      @(negedge trigger_clk);
      chk("rst_miso", miso, 0);
      chk("rst_oe", miso_oe, 0);
      chk("rst_tx_ready", tx_ready, 1);
      chk("rst_rx_valid", rx_valid, 0);
      chk("rst_rx_data", rx_data, 0);
      chk("rst_busy", busy, 0);
      chk("rst_overrun", overrun, 0);
      chk("rst_underrun", underrun, 0);
      #1 rst_n = 1'b1;
      wait_cyc(4);
      quiet = 1'b1;

      // 1: mode 0 exchange
      push_tx(8'hA5);
      mo_bytes[0] = 8'h3C;
      run_frame(1'b0, 1'b0, 8);
      chk("t1_master_rx", got[0], 8'hA5);
      pop_rx(8'h3C);
      clear_errs();

      // 2: modes 1..3
      for (int m = 1; m < 4; m++) begin
         push_tx(8'h81);
         mo_bytes[0] = 8'h7E;
         run_frame(m[1], m[0], 8);
         chk("t2_master_rx", got[0], 8'h81);
         pop_rx(8'h7E);
         clear_errs();
      end

      // 3: underrun, idle fill
      mo_bytes[0] = 8'h55;
      run_frame(1'b0, 1'b0, 8);
      chk("t3_master_rx", got[0], 8'hFF);
      @(negedge trigger_clk) chk("t3_underrun", underrun, 1);
      pop_rx(8'h55);
      clear_errs();
      @(negedge trigger_clk) chk("t3_underrun_clr", underrun, 0);

      // 4: back-to-back bytes with no reader
      mo_bytes[0] = 8'h01; mo_bytes[1] = 8'h02; mo_bytes[2] = 8'h03;
      run_frame(1'b0, 1'b0, 24);
      chk("t4_master_rx2", got[2], 8'hFF);
`ifdef SPI_SLAVE_RXFIFO_EN
      @(negedge trigger_clk) chk("t4_overrun", overrun, 0);
      pop_rx(8'h01);
      pop_rx(8'h02);
      pop_rx(8'h03);
`else
      @(negedge trigger_clk) chk("t4_overrun", overrun, 1);
      pop_rx(8'h01);
`endif
      clear_errs();

      // 5: aborted partial frame, then a full one
      mo_bytes[0] = 8'h1F;
      run_frame(1'b0, 1'b0, 5);
      @(negedge trigger_clk) chk("t5_no_rx", rx_valid, 0);
      mo_bytes[0] = 8'hC3;
      run_frame(1'b1, 1'b1, 8);
      @(negedge trigger_clk) chk("t5_rx_data", rx_data, 8'hC3);

      // 6: reset mid-frame (with rx pending and flags set)
      quiet = 1'b0;
      cpol = 1'b0; cpha = 1'b0; sclk = 1'b0;
      wait_cyc(4);
      cs_n = 1'b0;
      wait_cyc(HALF);
      @(negedge trigger_clk);
      tx_data  = 8'h99;
      tx_valid = 1'b1;
      @(posedge trigger_clk);
      #1 tx_valid = 1'b0;
      sclk = 1'b1;
      wait_cyc(HALF);
      sclk = 1'b0;
      wait_cyc(3);
      chk("t6_pre_busy", busy, 1);
      chk("t6_pre_tx_ready", tx_ready, 0);
      rst_n = 1'b0;
      #1;
      chk("t6_miso", miso, 0);
      chk("t6_oe", miso_oe, 0);
      chk("t6_tx_ready", tx_ready, 1);
      chk("t6_rx_valid", rx_valid, 0);
      chk("t6_rx_data", rx_data, 0);
      chk("t6_busy", busy, 0);
      chk("t6_overrun", overrun, 0);
      chk("t6_underrun", underrun, 0);
      cs_n = 1'b1;
      wait_cyc(2);
      rst_n = 1'b1;
      txq.delete();
      rxq.delete();
      exp_ovr = 1'b0;
      exp_unr = 1'b0;
      wait_cyc(4);
      quiet = 1'b1;
      push_tx(8'h5A);
      mo_bytes[0] = 8'h96;
      run_frame(1'b0, 1'b0, 8);
      chk("t6_master_rx", got[0], 8'h5A);
      pop_rx(8'h96);
      clear_errs();

      quiet = 1'b0;
      wait_cyc(2);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
